int_mult_arbiter: RTL and testbench

Shares one pipelined 54x54 integer multiplier between `NUM_REQ` requesters, for example the floating-point multiplier, a second FP lane and a modular-reduction unit. It arbitrates operand issue one grant per cycle, drives the multiplier operand bus, and tracks each in-flight product with a one-hot tag pipeline. The matching result is returned to the originating requester exactly `MULT_LATENCY` cycles after the grant. It sits between the requesters' `mult_a`/`mult_b`/`int_mult_result` ports and the single DSP multiplier instance.

---
 rtl/int_mult_arbiter_pkg.sv | 19 +
 rtl/int_mult_arbiter_if.sv | 32 +++
 rtl/int_mult_arbiter_rr_arbiter.sv | 67 ++++++
 rtl/int_mult_arbiter.sv | 69 ++++++
 tb/tb_int_mult_arbiter.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/int_mult_arbiter_pkg.sv
// Shared constants and types for the integer multiplier arbiter.
// Optional feature macro used by this slice: INT_MULT_ARB_PRIO0_EN.
package int_mult_pkg;

    localparam int MULT_OPERAND_BITS    = 54;
    localparam int MULT_RESULT_BITS     = 108;
    // Matches the FP multiplier's fixed 3-cycle product expectation.
    localparam int MULT_LATENCY_DEFAULT = 3;
    localparam int NUM_REQ_DEFAULT      = 3;

    typedef logic [MULT_OPERAND_BITS-1:0] mult_operand_t;
    typedef logic [MULT_RESULT_BITS-1:0]  mult_result_t;

    // Wrap an index that has run past n back into the range lo..n-1.
    function automatic int rr_wrap(input int idx, input int lo, input int n);
        return (idx >= n) ? idx - (n - lo) : idx;
    endfunction

endpackage

// File: rtl/int_mult_arbiter_if.sv
// Requester-side and multiplier-side bus of the shared integer multiplier.
// slave = arbiter side, master = requesters plus multiplier.
interface int_mult_arbiter_if
    import int_mult_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT
);

    // Handshake: req[i] is valid and gnt[i] is ready; a product issue happens in
    // the cycle both are high. req and operands stay stable until gnt is seen.
    logic [NUM_REQ-1:0]                   req;
    logic [NUM_REQ*MULT_OPERAND_BITS-1:0] req_a;
    logic [NUM_REQ*MULT_OPERAND_BITS-1:0] req_b;
    logic [NUM_REQ-1:0]                   gnt;
    mult_operand_t                        mult_a;
    mult_operand_t                        mult_b;
    mult_result_t                         int_mult_result;
    logic [NUM_REQ-1:0]                   rsp_valid;
    mult_result_t                         rsp_result;
    logic                                 busy;

    modport slave (
        input  req, req_a, req_b, int_mult_result,
        output gnt, mult_a, mult_b, rsp_valid, rsp_result, busy
    );

    modport master (
        output req, req_a, req_b, int_mult_result,
        input  gnt, mult_a, mult_b, rsp_valid, rsp_result, busy
    );

endinterface

// File: rtl/int_mult_arbiter_rr_arbiter.sv
// Round-robin one-hot arbiter with registered pointer.
// INT_MULT_ARB_PRIO0_EN gives requester 0 absolute priority outside the rotation.
module rr_arbiter
    import int_mult_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt
);

    localparam int PTR_W = $clog2(NUM_REQ);
`ifdef INT_MULT_ARB_PRIO0_EN
    localparam int RR_LO = 1;
`else
    localparam int RR_LO = 0;
`endif

    typedef logic [PTR_W-1:0] ptr_t;

    ptr_t               ptr_q;
    ptr_t               ptr_nxt;
    logic [NUM_REQ-1:0] rr_gnt;
    logic [NUM_REQ-1:0] gnt_d;
    logic               rr_hit;
    logic               advance;

    // Search outward from ptr_q; the first requester hit in that order wins.
    always_comb begin
        rr_gnt  = '0;
        rr_hit  = 1'b0;
        ptr_nxt = ptr_q;
        for (int off = 0; off < NUM_REQ - RR_LO; off++) begin
            for (int i = RR_LO; i < NUM_REQ; i++) begin
                if (!rr_hit && req[i] && (i == rr_wrap(int'(ptr_q) + off, RR_LO, NUM_REQ))) begin
                    rr_hit    = 1'b1;
                    rr_gnt[i] = 1'b1;
                    ptr_nxt   = ptr_t'(rr_wrap(i + 1, RR_LO, NUM_REQ));
                end
            end
        end
    end

    always_comb begin
        gnt_d   = rr_gnt;
        advance = rr_hit;
`ifdef INT_MULT_ARB_PRIO0_EN
        if (req[0]) begin
            gnt_d    = '0;
            gnt_d[0] = 1'b1;
            advance  = 1'b0;
        end
`endif
        gnt = rst ? '0 : gnt_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= ptr_t'(RR_LO);
        end else if (advance) begin
            ptr_q <= ptr_nxt;
        end
    end

endmodule

// File: rtl/int_mult_arbiter.sv
// Shares one pipelined 54x54 multiplier between NUM_REQ requesters and routes
// each product back by a one-hot tag pipeline. Option: INT_MULT_ARB_PRIO0_EN.
module int_mult_arbiter
    import int_mult_pkg::*;
#(
    parameter int NUM_REQ      = NUM_REQ_DEFAULT,
    parameter int MULT_LATENCY = MULT_LATENCY_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    int_mult_arbiter_if.slave  bus
);

    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] tag_q [MULT_LATENCY];
    mult_operand_t      mult_a_d;
    mult_operand_t      mult_b_d;
    logic               busy_d;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clk (clk),
        .rst (rst),
        .req (bus.req),
        .gnt (gnt)
    );

    // Idle cycles drive zero operands to keep the DSP quiet.
    always_comb begin
        mult_a_d = '0;
        mult_b_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                mult_a_d = mult_a_d | bus.req_a[i*MULT_OPERAND_BITS +: MULT_OPERAND_BITS];
                mult_b_d = mult_b_d | bus.req_b[i*MULT_OPERAND_BITS +: MULT_OPERAND_BITS];
            end
        end
    end

    // Tags must clear on reset so stale DSP outputs are never claimed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < MULT_LATENCY; j++) begin
                tag_q[j] <= '0;
            end
        end else begin
            tag_q[0] <= gnt;
            for (int j = 1; j < MULT_LATENCY; j++) begin
                tag_q[j] <= tag_q[j-1];
            end
        end
    end

    always_comb begin
        busy_d = 1'b0;
        for (int j = 0; j < MULT_LATENCY; j++) begin
            busy_d = busy_d | (|tag_q[j]);
        end
    end

    assign bus.gnt        = gnt;
    assign bus.mult_a     = mult_a_d;
    assign bus.mult_b     = mult_b_d;
    assign bus.rsp_valid  = rst ? '0 : tag_q[MULT_LATENCY-1];
    assign bus.rsp_result = bus.int_mult_result;
    assign bus.busy       = busy_d;

endmodule

// File: tb/tb_int_mult_arbiter.sv
// Self-checking bench for int_mult_arbiter: round-robin reference model,
// delay-LAT multiplier model and a scoreboard of expected responses.
module tb_int_mult_arbiter;
  import int_mult_pkg::*;

  localparam int N   = 3;
  localparam int LAT = 3;
  localparam int W   = N + MULT_RESULT_BITS;
`ifdef INT_MULT_ARB_PRIO0_EN
  localparam int PTR_RESET = 1;
`else
  localparam int PTR_RESET = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int_mult_arbiter_if #(.NUM_REQ(N)) bus ();

  int_mult_arbiter #(
    .NUM_REQ      (N),
    .MULT_LATENCY (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- requester state ----------------
  logic [N-1:0]  req_r = '0;
  mult_operand_t a_r [N] = '{default: '0};
  mult_operand_t b_r [N] = '{default: '0};
  logic [N-1:0]  last_gnt = '0;

  always_comb begin
    bus.req   = req_r;
    bus.req_a = '0;
    bus.req_b = '0;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*MULT_OPERAND_BITS +: MULT_OPERAND_BITS] = a_r[i];
      bus.req_b[i*MULT_OPERAND_BITS +: MULT_OPERAND_BITS] = b_r[i];
    end
  end

  // Shared DSP modelled as a plain LAT-deep product pipeline, never flushed.
  mult_result_t dsp_pipe [LAT] = '{default: '0};
  always @(posedge clk) begin
    for (int j = LAT - 1; j > 0; j--) dsp_pipe[j] <= dsp_pipe[j-1];
    dsp_pipe[0] <= mult_result_t'(bus.mult_a) * mult_result_t'(bus.mult_b);
  end
  assign bus.int_mult_result = dsp_pipe[LAT-1];

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q [$];
  int           due_q [$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           ptr_m = PTR_RESET;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [N-1:0] model_gnt(input logic [N-1:0] r, input int p);
    logic [N-1:0] g;
    int idx;
    g = '0;
`ifdef INT_MULT_ARB_PRIO0_EN
    if (r[0]) begin
      g[0] = 1'b1;
      return g;
    end
    for (int off = 0; off < N - 1; off++) begin
      idx = 1 + ((p - 1 + off) % (N - 1));
      if (r[idx]) begin
        g[idx] = 1'b1;
        return g;
      end
    end
`else
    for (int off = 0; off < N; off++) begin
      idx = (p + off) % N;
      if (r[idx]) begin
        g[idx] = 1'b1;
        return g;
      end
    end
`endif
    return g;
  endfunction

  always @(negedge clk) begin
    logic [N-1:0]  eg;
    logic [W-1:0]  e;
    logic          busy_e;
    mult_operand_t ea, eb;
    if (rst) begin
      check("rst_gnt", 128'(bus.gnt), 128'(0));
      check("rst_rsp_valid", 128'(bus.rsp_valid), 128'(0));
      check("rst_busy", 128'(bus.busy), 128'(0));
      check("rst_mult_a", 128'(bus.mult_a), 128'(0));
      check("rst_mult_b", 128'(bus.mult_b), 128'(0));
      check("rst_rsp_result", 128'(bus.rsp_result), 128'(bus.int_mult_result));
      exp_q.delete();
      due_q.delete();
      ptr_m    = PTR_RESET;
      last_gnt = '0;
    end else begin
      busy_e = 1'b0;
      foreach (due_q[q]) if (due_q[q] < cyc + LAT) busy_e = 1'b1;
      check("busy", 128'(bus.busy), 128'(busy_e));

      if (due_q.size() > 0 && due_q[0] == cyc) begin
        void'(due_q.pop_front());
        e = exp_q.pop_front();
        check("rsp_valid", 128'(bus.rsp_valid), 128'(e[W-1 -: N]));
        check("rsp_result", 128'(bus.rsp_result), 128'(e[MULT_RESULT_BITS-1:0]));
      end else begin
        check("rsp_idle", 128'(bus.rsp_valid), 128'(0));
      end

      eg = model_gnt(req_r, ptr_m);
      check("gnt", 128'(bus.gnt), 128'(eg));
      ea = '0;
      eb = '0;
      for (int i = 0; i < N; i++) begin
        if (eg[i]) begin
          ea = a_r[i];
          eb = b_r[i];
          if (!(i == 0 && PTR_RESET == 1)) ptr_m = (i + 1 >= N) ? PTR_RESET : i + 1;
        end
      end
      check("mult_a", 128'(bus.mult_a), 128'(ea));
      check("mult_b", 128'(bus.mult_b), 128'(eb));
      if (eg != '0) begin
        exp_q.push_back({eg, mult_result_t'(ea) * mult_result_t'(eb)});
        due_q.push_back(cyc + LAT);
      end
      last_gnt = bus.gnt;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic mult_operand_t rand_op();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    case ($urandom_range(0, 7))
      0:       return '1;
      1:       return '0;
      default: return t[MULT_OPERAND_BITS-1:0];
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic on, input mult_operand_t a, input mult_operand_t b);
    req_r[i] = on;
    a_r[i]   = a;
    b_r[i]   = b;
  endtask

  // Granted requesters either retire or issue a fresh operand pair.
  task automatic after_grant(input logic keep);
    for (int i = 0; i < N; i++) begin
      if (last_gnt[i]) set_req(i, keep, rand_op(), rand_op());
    end
  endtask

  task automatic random_step();
    for (int i = 0; i < N; i++) begin
      if (last_gnt[i]) set_req(i, ($urandom_range(0, 3) != 0), rand_op(), rand_op());
      else if (!req_r[i] && $urandom_range(0, 2) == 0) set_req(i, 1'b1, rand_op(), rand_op());
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) tick();
    rst = 1'b0;

    // Single request from requester 1: 3 * 7.
    repeat (2) tick();
    set_req(1, 1'b1, 54'd3, 54'd7);
    tick();
    after_grant(1'b0);
    repeat (LAT + 2) tick();

    // Fairness: all three hold requests for nine cycles.
    for (int i = 0; i < N; i++) set_req(i, 1'b1, rand_op(), rand_op());
    repeat (9) begin
      tick();
      after_grant(1'b1);
    end
    req_r = '0;
    repeat (LAT + 1) tick();

    // Wrap and skip: move the pointer to 2, then request 0 and 1.
    set_req(1, 1'b1, 54'd5, 54'd9);
    tick();
    after_grant(1'b0);
    set_req(0, 1'b1, 54'd11, 54'd13);
    set_req(1, 1'b1, 54'd17, 54'd19);
    tick();
    after_grant(1'b0);
    tick();
    after_grant(1'b0);
    repeat (LAT + 1) tick();

    // Reset while two products are in flight.
    for (int i = 0; i < N; i++) set_req(i, 1'b1, rand_op(), rand_op());
    repeat (2) begin
      tick();
      after_grant(1'b1);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (4) begin
      tick();
      after_grant(1'b1);
    end
    req_r = '0;
    repeat (LAT + 1) tick();

    // Random traffic.
    repeat (10000) begin
      tick();
      random_step();
    end
    req_r = '0;
    repeat (LAT + 2) tick();
    check("drain", 128'(due_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
